// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package instruction_fetch_controller_pkg;

  localparam int DEF_ADDR_WIDTH = 48;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PC_STEP    = 4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_controller_buffer.sv
// Single-entry valid/ready register holding a fetched word and its PC.
// Flush wins over load so a redirect never lets a stale word through.
module fetch_output_buffer #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  consume,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Capture on load, drop on consume or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one memory request at a
// time, buffers the returned word for decode and handles redirects,
// including draining a request that was already on the bus.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = DEF_PC_STEP
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  fetchEnable,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPc,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memReady,
  input  logic [DATA_WIDTH-1:0] memRdata,
  output logic                  instValid,
  input  logic                  instReady,
  output logic [DATA_WIDTH-1:0] instData,
  output logic [ADDR_WIDTH-1:0] instPc,
  output logic                  busy
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  buf_load;

  assign pc_inc          = pc + ADDR_WIDTH'(PC_STEP);
  assign redirect_target = redirectPc & ~ADDR_WIDTH'(3);

  // mem_addr tracks pc except in DRAIN, where the abandoned request's
  // address must stay on the bus while pc already holds the new target.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_req  <= 1'b0;
    end else if (redirectValid) begin
      pc <= redirect_target;
      if (mem_req && !memReady) begin
        state <= DRAIN;
      end else begin
        state    <= fetchEnable ? FETCH : IDLE;
        mem_req  <= fetchEnable;
        mem_addr <= redirect_target;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fetchEnable) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (memReady) begin
            state    <= HOLD;
            mem_req  <= 1'b0;
            pc       <= pc_inc;
            mem_addr <= pc_inc;
          end
        end
        HOLD: begin
          if (instReady) begin
            state   <= fetchEnable ? FETCH : IDLE;
            mem_req <= fetchEnable;
          end
        end
        DRAIN: begin
          if (memReady) begin
            state    <= fetchEnable ? FETCH : IDLE;
            mem_req  <= fetchEnable;
            mem_addr <= pc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Only a live (non-squashed) FETCH response reaches the buffer
  assign buf_load = (state == FETCH) && memReady && !redirectValid;

  fetch_output_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (resetN),
    .load     (buf_load),
    .consume  (instValid && instReady),
    .flush    (redirectValid),
    .load_data(memRdata),
    .load_pc  (pc),
    .valid    (instValid),
    .data     (instData),
    .pc       (instPc)
  );

  assign memReq  = mem_req;
  assign memAddr = mem_addr;
  assign busy    = mem_req;

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
- Sequences instruction fetches from the instructionMemory block for the RISC-V core.
- Owns the program counter and issues one request at a time over a req/ready handshake.
- Holds the returned word in a one-entry output buffer, presented to decode via valid/ready.
- Handles branch/jump redirects, including squashing a fetch already in flight.

Parameters:
- ADDR_WIDTH, 48, width of the instruction address and PC.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 48'h000000000000, PC value loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction in bytes.

Ports:
- clk  input  1  system clock, all state on rising edge
- resetN  input  1  asynchronous active-low reset
- fetchEnable  input  1  permits new fetches to start; an in-flight fetch always completes
- redirectValid  input  1  one-cycle pulse: load redirectPc and discard pending/buffered instruction
- redirectPc  input  ADDR_WIDTH  redirect target; bits [1:0] forced to 0 internally
- memReq  output  1  fetch request to instruction memory
- memAddr  output  ADDR_WIDTH  fetch address, stable while memReq=1
- memReady  input  1  memory accepts request; memRdata valid this cycle
- memRdata  input  DATA_WIDTH  instruction word from memory
- instValid  output  1  output buffer holds a valid instruction
- instReady  input  1  decode consumes instruction when instValid&&instReady
- instData  output  DATA_WIDTH  buffered instruction
- instPc  output  ADDR_WIDTH  PC of the buffered instruction
- busy  output  1  a memory request is outstanding (memReq=1)

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE, pc=RESET_PC.
  - memReq=0, memAddr=RESET_PC, instValid=0, instData=0, instPc=0, busy=0.
  - Reset asserted mid-fetch abandons the request immediately; memory must tolerate memReq dropping.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE:
  - If fetchEnable=1 and no redirect, go to FETCH next cycle.
  - A redirect loads pc and stays in IDLE when fetchEnable=0.
- FETCH:
  - memReq=1, memAddr=pc. Address and request are held stable until memReady=1.
  - memReady may arrive in the first FETCH cycle (zero-wait memory).
  - On memReady:
    - instData<=memRdata, instPc<=pc, instValid<=1.
    - pc<=pc+PC_STEP, wrapping modulo 2^ADDR_WIDTH.
    - Go to HOLD.
- HOLD:
  - instValid=1; no request is issued.
  - On instValid&&instReady: instValid<=0. Next state is FETCH if fetchEnable=1, else IDLE.
  - Minimum fetch-to-fetch spacing is 2 cycles; throughput is at most 1 instruction per 2 cycles with zero-wait memory.
- DRAIN:
  - memReq=1 with the old memAddr until memReady.
  - The response is discarded (instValid stays 0).
  - Then FETCH if fetchEnable=1, else IDLE. pc already holds the redirect target.
- Redirect (redirectValid=1) has highest priority in every state:
  - pc<=redirectPc&~3 and instValid<=0, including dropping a buffered instruction even when instReady=1 that cycle.
  - FETCH with memReady=0: go to DRAIN.
  - FETCH with memReady=1: data discarded, go to FETCH (or IDLE if fetchEnable=0).
  - IDLE, HOLD, DRAIN: go to FETCH (or IDLE if fetchEnable=0). DRAIN with memReady=0 stays in DRAIN.
- fetchEnable=0 during FETCH or DRAIN does not cancel the request; it only blocks the next one.
- busy equals memReq, registered from state.
- PC wrap: RESET_PC=2^ADDR_WIDTH-4 fetches that address, then address 0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, DRAIN=2'd3)
  - PC_STEP
  - default ADDR_WIDTH and DATA_WIDTH
- One natural sub-module, fetch_output_buffer: single-entry valid/ready register holding instData/instPc, with load, consume and flush controls.
- FSM and PC stay in the top module.

Test Plan:
1. Reset release, fetchEnable=1, memory with memReady tied to 1 returning 32'h00000013 → memReq at cycle 1 with memAddr=0; instValid cycle 2 with instPc=0; second request memAddr=4 after consume; sustained rate 1 per 2 cycles.
2. Back-pressure: memory with 3-cycle memReady, instReady=0 for 5 cycles in HOLD → memReq stays 0; instData/instPc stable; next fetch addr=pc+4 only after handshake.
3. Redirect during FETCH with memReady=0, redirectPc=48'h100 → state DRAIN; old memAddr held until memReady; discarded data never appears on instValid; next memAddr=48'h100.
4. Redirect in HOLD with instReady=1 same cycle, redirectPc=48'h203 → buffered instruction dropped; next memAddr=48'h200.
5. Wrap: RESET_PC=48'hFFFFFFFFFFFC → instPc=48'hFFFFFFFFFFFC then 0.
6. Reset asserted while memReq=1 and instValid=1 → memReq, instValid, busy go to 0 asynchronously; pc=RESET_PC after release.
